// File: rtl/main_mem_arbiter_if.sv
// main_mem_arbiter_if
// Bundles the two requester ports, the RAM-side bus and the debug counter
// of main_mem_arbiter.
//   slave  : the arbiter (takes requests and RAM read data; returns grants,
//            read data, RAM controls and conflict_cnt)
//   master : the requesters/RAM environment driving the arbiter
// Signals keep the original port names:
//   req0/1, rw0/1, addr0/1, wdata0/1   requester inputs
//   gnt0/1, rdata0/1, rvalid0/1        requester outputs
//   mem_addr, mem_data, mem_wren       to RAM;  mem_q from RAM
//   conflict_cnt                       saturating contention counter
interface main_mem_arbiter_if #(
    parameter int AW = 12,
    parameter int DW = 16
);
    logic          req0;
    logic          req1;
    logic          rw0;
    logic          rw1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          gnt0;
    logic          gnt1;
    logic [DW-1:0] rdata0;
    logic [DW-1:0] rdata1;
    logic          rvalid0;
    logic          rvalid1;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_wren;
    logic [DW-1:0] mem_q;
    logic [15:0]   conflict_cnt;

    modport slave (
        input  req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1, mem_q,
        output gnt0, gnt1, rdata0, rdata1, rvalid0, rvalid1,
               mem_addr, mem_data, mem_wren, conflict_cnt
    );

    modport master (
        output req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1, mem_q,
        input  gnt0, gnt1, rdata0, rdata1, rvalid0, rvalid1,
               mem_addr, mem_data, mem_wren, conflict_cnt
    );
endinterface

// File: rtl/main_mem_arbiter.sv
// main_mem_arbiter
// Round-robin arbiter sharing the single-port main data RAM between the
// processor data port (port 0) and the host/loader port (port 1).
// Grants are combinational, read data is registered back to the winner and
// a saturating counter records cycles with both ports requesting.
// Optional burst lock: define MAIN_MEM_ARB_BURST_EN to let the current owner
// keep the RAM for up to BURST_MAX consecutive grants under contention
// (BURST_MAX exists only in that build).
// Ports:
//   clock  system clock, rising edge
//   reset  asynchronous, active-high
//   bus    main_mem_arbiter_if.slave (requesters, RAM bus, conflict_cnt)
module main_mem_arbiter #(
    parameter int AW = 12,
    parameter int DW = 16
`ifdef MAIN_MEM_ARB_BURST_EN
    ,
    parameter int BURST_MAX = 4
`endif
) (
    input logic              clock,
    input logic              reset,
    main_mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          last_q, last_d;
    logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic          rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic [15:0]   conflict_q, conflict_d;
    logic          tie_to0, gnt0, gnt1;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_wren;

`ifdef MAIN_MEM_ARB_BURST_EN
    localparam int BW = $clog2(BURST_MAX + 1);
    logic [BW-1:0] burst_q, burst_d;
`endif

    // Arbitration: a tie goes to the port not served last, unless the burst
    // lock holds it with the current owner.
    always_comb begin
        tie_to0 = last_q;
`ifdef MAIN_MEM_ARB_BURST_EN
        if (state_q == OWN0 && burst_q < BW'(BURST_MAX)) begin
            tie_to0 = 1'b1;
        end else if (state_q == OWN1 && burst_q < BW'(BURST_MAX)) begin
            tie_to0 = 1'b0;
        end
`endif
        gnt0 = ~reset & bus.req0 & (~bus.req1 | tie_to0);
        gnt1 = ~reset & bus.req1 & (~bus.req0 | ~tie_to0);
    end

    always_comb begin
        mem_addr = '0;
        mem_data = '0;
        mem_wren = 1'b0;
        if (gnt0) begin
            mem_addr = bus.addr0;
            mem_data = bus.wdata0;
            mem_wren = bus.rw0;
        end else if (gnt1) begin
            mem_addr = bus.addr1;
            mem_data = bus.wdata1;
            mem_wren = bus.rw1;
        end
    end

    always_comb begin
        state_d    = IDLE;
        last_d     = last_q;
        rvalid0_d  = 1'b0;
        rvalid1_d  = 1'b0;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        conflict_d = conflict_q;
        if (gnt0) begin
            state_d = OWN0;
            last_d  = 1'b0;
            if (!bus.rw0) begin
                rvalid0_d = 1'b1;
                rdata0_d  = bus.mem_q;
            end
        end else if (gnt1) begin
            state_d = OWN1;
            last_d  = 1'b1;
            if (!bus.rw1) begin
                rvalid1_d = 1'b1;
                rdata1_d  = bus.mem_q;
            end
        end
        if (bus.req0 && bus.req1 && conflict_q != '1) begin
            conflict_d = conflict_q + 16'd1;
        end
    end

`ifdef MAIN_MEM_ARB_BURST_EN
    // Counts consecutive grants to the same owner; a change of owner restarts
    // at 1 and a cycle without grant clears it.
    always_comb begin
        burst_d = '0;
        if ((gnt0 && state_q == OWN0) || (gnt1 && state_q == OWN1)) begin
            burst_d = (burst_q < BW'(BURST_MAX)) ? burst_q + BW'(1) : burst_q;
        end else if (gnt0 || gnt1) begin
            burst_d = BW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            burst_q <= '0;
        end else begin
            burst_q <= burst_d;
        end
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            conflict_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            conflict_q <= conflict_d;
        end
    end

    assign bus.gnt0         = gnt0;
    assign bus.gnt1         = gnt1;
    assign bus.mem_addr     = mem_addr;
    assign bus.mem_data     = mem_data;
    assign bus.mem_wren     = mem_wren;
    assign bus.rdata0       = rdata0_q;
    assign bus.rdata1       = rdata1_q;
    assign bus.rvalid0      = rvalid0_q;
    assign bus.rvalid1      = rvalid1_q;
    assign bus.conflict_cnt = conflict_q;

endmodule

// File: tb/tb_main_mem_arbiter.sv
// tb_main_mem_arbiter
// Bench for main_mem_arbiter: a RAM stand-in clocked on the falling edge, a
// transaction-level model checked against the DUT on every falling edge, and
// directed scenarios with literal expectations.
// Build with MAIN_MEM_ARB_BURST_EN defined to exercise the burst lock.
module tb_main_mem_arbiter;
    localparam int AW = 12;
    localparam int DW = 16;
`ifdef MAIN_MEM_ARB_BURST_EN
    localparam int BMAX = 4;
    localparam int NPAT = 8;
    bit pat [NPAT] = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
    localparam int NPAT = 4;
    bit pat [NPAT] = '{0, 1, 0, 1};
`endif

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    main_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
    main_mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // RAM stand-in, inverted clock
    logic [DW-1:0] ram  [0:4095];
    logic [DW-1:0] mram [0:4095];
    always @(negedge clock) begin
        if (bus.mem_wren) ram[bus.mem_addr] <= bus.mem_data;
        bus.mem_q <= ram[bus.mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: who was served last cycle, length of its current run, and the
    // values the registered outputs must hold.
    int            m_owner;
    int            m_run;
    bit            m_last;
    bit            m_rv0, m_rv1;
    logic [DW-1:0] m_rd0, m_rd1;
    logic [15:0]   m_conf;

    always @(negedge clock) begin
        int            win;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        bit            ew;
        if (reset) begin
            m_owner = -1; m_run = 0; m_last = 1'b1;
            m_rv0 = 1'b0; m_rv1 = 1'b0; m_rd0 = '0; m_rd1 = '0; m_conf = '0;
            chk("rst_gnt0", 32'(bus.gnt0), 0);
            chk("rst_gnt1", 32'(bus.gnt1), 0);
            chk("rst_wren", 32'(bus.mem_wren), 0);
            chk("rst_rvalid0", 32'(bus.rvalid0), 0);
            chk("rst_rvalid1", 32'(bus.rvalid1), 0);
            chk("rst_rdata0", 32'(bus.rdata0), 0);
            chk("rst_rdata1", 32'(bus.rdata1), 0);
            chk("rst_conflict", 32'(bus.conflict_cnt), 0);
        end else begin
            win = -1;
            if (bus.req0 && bus.req1) begin
                win = m_last ? 0 : 1;
`ifdef MAIN_MEM_ARB_BURST_EN
                if (m_owner >= 0 && m_run < BMAX) win = m_owner;
`endif
            end else if (bus.req0) begin
                win = 0;
            end else if (bus.req1) begin
                win = 1;
            end
            ea = (win == 0) ? bus.addr0 : (win == 1) ? bus.addr1 : '0;
            ed = (win == 0) ? bus.wdata0 : (win == 1) ? bus.wdata1 : '0;
            ew = (win == 0) ? bus.rw0 : (win == 1) ? bus.rw1 : 1'b0;
            chk("gnt0", 32'(bus.gnt0), 32'(win == 0));
            chk("gnt1", 32'(bus.gnt1), 32'(win == 1));
            chk("mem_addr", 32'(bus.mem_addr), 32'(ea));
            chk("mem_data", 32'(bus.mem_data), 32'(ed));
            chk("mem_wren", 32'(bus.mem_wren), 32'(ew));
            chk("rvalid0", 32'(bus.rvalid0), 32'(m_rv0));
            chk("rvalid1", 32'(bus.rvalid1), 32'(m_rv1));
            chk("rdata0", 32'(bus.rdata0), 32'(m_rd0));
            chk("rdata1", 32'(bus.rdata1), 32'(m_rd1));
            chk("conflict", 32'(bus.conflict_cnt), 32'(m_conf));
            m_rv0 = 1'b0;
            m_rv1 = 1'b0;
            if (win >= 0) begin
                m_run   = (m_owner == win) ? m_run + 1 : 1;
                m_owner = win;
                m_last  = (win == 1);
                if (ew) begin
                    mram[ea] = ed;
                end else if (win == 0) begin
                    m_rv0 = 1'b1; m_rd0 = mram[ea];
                end else begin
                    m_rv1 = 1'b1; m_rd1 = mram[ea];
                end
            end else begin
                m_owner = -1;
                m_run   = 0;
            end
            if (bus.req0 && bus.req1 && m_conf != 16'hFFFF) m_conf = m_conf + 16'd1;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clock);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            ram[i]  = 16'(i * 7 + 16'h0100);
            mram[i] = 16'(i * 7 + 16'h0100);
        end
        ram[12'h010]  = 16'h1234;
        mram[12'h010] = 16'h1234;
        reset = 1'b1;
        bus.req0 = 0; bus.req1 = 0; bus.rw0 = 0; bus.rw1 = 0;
        bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
        repeat (2) tick();

        // first read after reset
        reset = 1'b0;
        bus.req0 = 1; bus.rw0 = 0; bus.addr0 = 12'h010;
        at_neg();
        chk("t1_gnt0", 32'(bus.gnt0), 1);
        chk("t1_addr", 32'(bus.mem_addr), 32'h010);
        tick();
        bus.req0 = 0;
        at_neg();
        chk("t1_rvalid0", 32'(bus.rvalid0), 1);
        chk("t1_rdata0", 32'(bus.rdata0), 32'h1234);

        // lone requester on port 1, address moving every cycle
        tick();
        bus.req1 = 1; bus.rw1 = 0;
        for (int i = 0; i < 3; i++) begin
            bus.addr1 = 12'(12'h100 + i);
            at_neg();
            chk("lone_gnt1", 32'(bus.gnt1), 1);
            tick();
        end

        // port 1 writes, port 0 reads it back
        bus.rw1 = 1; bus.addr1 = 12'h005; bus.wdata1 = 16'h00AA;
        at_neg();
        chk("wr_wren", 32'(bus.mem_wren), 1);
        chk("wr_data", 32'(bus.mem_data), 32'h00AA);
        tick();
        bus.req1 = 0; bus.rw1 = 0;
        bus.req0 = 1; bus.rw0 = 0; bus.addr0 = 12'h005;
        at_neg();
        chk("rd_wren", 32'(bus.mem_wren), 0);
        tick();
        bus.req0 = 0;
        at_neg();
        chk("rd_rdata0", 32'(bus.rdata0), 32'h00AA);

        // contention from reset
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.req0 = 1; bus.req1 = 1; bus.rw0 = 0; bus.rw1 = 0;
        for (int i = 0; i < NPAT; i++) begin
            bus.addr0 = 12'(12'h020 + i);
            bus.addr1 = 12'(12'h040 + i);
            at_neg();
            chk("pat_gnt1", 32'(bus.gnt1), 32'(pat[i]));
            chk("pat_gnt0", 32'(bus.gnt0), 32'(!pat[i]));
            tick();
        end
        at_neg();
        chk("pat_conflict", 32'(bus.conflict_cnt), 32'(NPAT));

        // reset during a port-0 read grant
        tick();
        bus.req1 = 0; bus.addr0 = 12'h010;
        at_neg();
        tick();
        bus.addr0 = 12'h011;
        #1 reset = 1'b1;
        at_neg();
        chk("mid_gnt0", 32'(bus.gnt0), 0);
        chk("mid_rvalid0", 32'(bus.rvalid0), 0);
        chk("mid_wren", 32'(bus.mem_wren), 0);
        tick();
        reset = 1'b0;
        bus.req0 = 1; bus.req1 = 1;
        at_neg();
        chk("post_rst_gnt0", 32'(bus.gnt0), 1);
        chk("post_rst_gnt1", 32'(bus.gnt1), 0);

        // saturation: preload the counter one below the ceiling
        force dut.conflict_d = 16'hFFFE;
        tick();
        release dut.conflict_d;
        m_conf = 16'hFFFE;
        at_neg();
        chk("sat_pre", 32'(bus.conflict_cnt), 32'hFFFE);
        for (int i = 0; i < 3; i++) begin
            tick();
            at_neg();
            chk("sat_hold", 32'(bus.conflict_cnt), 32'hFFFF);
        end

        tick();
        bus.req0 = 0; bus.req1 = 0;
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/main_mem_arbiter.md
# main_mem_arbiter

Two-port arbiter that shares the single-port main data RAM (12-bit address, 16-bit data, clocked on the inverted system clock) between the processor's data port (port 0) and a host/loader port (port 1) used to preload or dump sort data. It sits between the requesters and the RAM and performs round-robin arbitration with an optional burst lock. It registers read data back to the winning requester and keeps a saturating contention counter for debug display.

## Interface
- `AW`, 12, address width
- `DW`, 16, data width
- `BURST_MAX`, 4, maximum consecutive grants to one owner while the other requests (burst build only; ≥1)

- `clock`  in  1  system clock; all registers on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `req0`, `req1`  in  1  access request, held until the matching `gnt` cycle
- `rw0`, `rw1`  in  1  1 = write, 0 = read
- `addr0`, `addr1`  in  AW  access address
- `wdata0`, `wdata1`  in  DW  write data
- `gnt0`, `gnt1`  out  1  combinational; access performed this cycle
- `rdata0`, `rdata1`  out  DW  registered read data
- `rvalid0`, `rvalid1`  out  1  one-cycle pulse; `rdata` is valid
- `mem_addr`  out  AW  to RAM address
- `mem_data`  out  DW  to RAM data
- `mem_wren`  out  1  to RAM write enable
- `mem_q`  in  DW  from RAM read data
- `conflict_cnt`  out  16  cycles with both requests high, saturating

## Operation
- Each grant cycle performs exactly one RAM access for the granted port. A requester advances its address/data on the rising edge that ends its grant cycle. It drops `req` on that edge if it has no further access.
- Grant is combinational from `req0/req1` and the registered state. At most one `gnt` is high. `gnt` is never high without its `req`.
- RAM mux: granted port's `addr`/`wdata` drive `mem_addr`/`mem_data`. `mem_wren = gnt & rw` of the granted port. With no grant, `mem_addr` and `mem_data` hold 0 and `mem_wren` = 0.
- State machine (`state`, `last`, `burst_cnt`):
  - IDLE: no owner. A single request is granted. If both request, the port ≠ `last` wins. At reset `last` = 1, so port 0 wins the first tie.
  - OWN0 / OWN1: entered on the edge after a grant to that port. `last` and `burst_cnt` update on every grant edge.
  - On any edge with no grant, the state returns to IDLE.
- Without burst: in OWNk, a tie goes to the other port, giving strict alternation under contention. A lone requester receives grants every cycle.
- Read return: on the edge ending a read grant to port k, `rdata_k` ← `mem_q` and `rvalid_k` pulses high for the following cycle. `rdata_k` holds its value until the next read for that port. Writes produce no `rvalid`.
- `conflict_cnt` increments on every edge where `req0 & req1`. It sticks at 0xFFFF.

## Timing
- Grant latency: 0 cycles (same cycle as `req` when the port wins).
- Read latency: `rvalid` one cycle after the `gnt` cycle.
- Throughput: one access per cycle total.
- Reset (asynchronous, any time, including mid-burst): `state` = IDLE, `last` = 1, `burst_cnt` = 0, `rdata0/1` = 0, `rvalid0/1` = 0, `conflict_cnt` = 0. `gnt0/1` and `mem_wren` are forced to 0 while `reset` is high. A pending `rvalid` is dropped.
- A requester that drops `req` in a cycle loses that cycle with no access. Changing `addr` while `req` is high without a grant is legal; the access uses the value present in the grant cycle.

## Configuration
- `MAIN_MEM_ARB_BURST_EN` defined:
  - In OWNk with `req_k` high, port k keeps the grant even when the other port requests, until `burst_cnt` reaches `BURST_MAX` grants.
  - The next tie then goes to the other port and `burst_cnt` resets to 1.
  - `burst_cnt` is cleared in IDLE.
- `MAIN_MEM_ARB_BURST_EN` undefined:
  - No burst lock; pure round-robin per cycle.
  - `burst_cnt` logic is not built.

## Test plan
- Reset release, `req0`=1, `rw0`=0, `addr0`=0x010, RAM[0x010]=0x1234 -> `gnt0` in the same cycle, `mem_addr`=0x010, next cycle `rvalid0`=1 and `rdata0`=0x1234.
- Both ports request continuously, burst undefined -> first grant to port 0, then strict alternation 0,1,0,1. `conflict_cnt` increments by 1 per cycle.
- Burst defined, `BURST_MAX`=4, both requesting continuously -> grant pattern 0,0,0,0,1,1,1,1,0…
- Port 1 writes 0x00AA to 0x005 while port 0 is idle, then port 0 reads 0x005 -> `mem_wren`=1 only in the port-1 grant cycle; `rdata0`=0x00AA.
- Reset asserted in the middle of a port-0 read grant -> `gnt0`, `mem_wren` and `rvalid0` go low immediately. After release with both requesting, the next tie goes to port 0.
- Force `conflict_cnt` to 0xFFFE and keep both requesting for 3 cycles -> counter reads 0xFFFF and stays there.
